// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - MDU_WIDTH : default operand/result width (one RUN cycle per bit)
//   - op_e      : operation encoding carried on the op port
//   - state_e   : sequencer states (IDLE -> RUN -> FIX -> IDLE)
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
// Purely combinational conditional two's-complement. Used by the multiply/
// divide unit both to take operand magnitudes and to re-apply result signs.
// Ports:
//   value_i  [W-1:0]  input value
//   negate_i          1 = output the two's complement, 0 = pass through
//   result_o [W-1:0]  conditionally negated value (modulo 2^W)
// ---------------------------------------------------------------------------
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o
);

  // Negating the most negative value wraps back onto itself, which is exactly
  // what both the magnitude step and the overflow case of DIV rely on.
  assign result_o = negate_i ? -value_i : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit owning the HI/LO register pair. One result
// bit is produced per RUN cycle (WIDTH cycles), followed by a FIX cycle that
// re-applies signs and loads HI/LO. The pipeline stalls on busy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op, a, b   launch request (accepted only in IDLE), opcode, operands
//   wr_hi, wr_lo      MTHI/MTLO write strobes, data on wdata (IDLE only)
//   busy              high while an operation is in flight
//   done              one-cycle pulse when hi/lo first show a new result
//   div_by_zero       set with done when a divide had a zero divisor
//   hi, lo            HI (product upper / remainder), LO (product lower / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   aRaw_q, aRaw_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               dbzPend_q, dbzPend_d;
  logic               dbzFlag_q, dbzFlag_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               opSigned;
  logic               opIsDiv;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divNext;

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  // Operand decode: only the signed opcodes look at the operand sign bits,
  // so unsigned operations latch the raw values unchanged.
  assign opSigned = (op == OP_MULT) || (op == OP_DIV);
  assign opIsDiv  = (op == OP_DIV)  || (op == OP_DIVU);
  assign signA    = opSigned & a[WIDTH-1];
  assign signB    = opSigned & b[WIDTH-1];

  cond_negate #(.W(WIDTH)) uMagA (
    .value_i  (a),
    .negate_i (signA),
    .result_o (magA)
  );

  cond_negate #(.W(WIDTH)) uMagB (
    .value_i  (b),
    .negate_i (signB),
    .result_o (magB)
  );

  // Shift-add multiply step. acc_q holds {partial product, remaining
  // multiplier bits}; the partial sum keeps its carry so nothing is lost
  // when the accumulator shifts right.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  // Restoring divide step. acc_q holds {partial remainder, dividend bits
  // still to shift in}; the quotient bits fill the low end as the dividend
  // shifts out. A set bit WIDTH on the trial difference means it went
  // negative, so the shifted remainder is kept instead.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd_q};
  assign divNext  = divDiff[WIDTH]
                  ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {divDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up for the FIX cycle: product and quotient follow the XOR of
  // the operand signs, the remainder follows the dividend.
  cond_negate #(.W(2*WIDTH)) uProdFix (
    .value_i  (acc_q),
    .negate_i (negRes_q),
    .result_o (prodFix)
  );

  cond_negate #(.W(WIDTH)) uQuoFix (
    .value_i  (acc_q[WIDTH-1:0]),
    .negate_i (negRes_q),
    .result_o (quoFix)
  );

  cond_negate #(.W(WIDTH)) uRemFix (
    .value_i  (acc_q[2*WIDTH-1:WIDTH]),
    .negate_i (negRem_q),
    .result_o (remFix)
  );

  // Next-state and datapath control. IDLE captures operands on start (start
  // beats any simultaneous MTHI/MTLO write), RUN iterates once per cycle for
  // WIDTH cycles, FIX commits the signed result to HI/LO and raises done for
  // the first IDLE cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    aRaw_d    = aRaw_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    dbzPend_d = dbzPend_q;
    dbzFlag_d = dbzFlag_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = CW'(WIDTH-1);
          isDiv_d   = opIsDiv;
          negRes_d  = signA ^ signB;
          negRem_d  = signA;
          dbzPend_d = opIsDiv && (b == '0);
          dbzFlag_d = 1'b0;
          aRaw_d    = a;
          opnd_d    = opIsDiv ? magB : magA;
          acc_d     = {{WIDTH{1'b0}}, (opIsDiv ? magA : magB)};
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end

      RUN: begin
        acc_d = isDiv_q ? divNext : mulNext;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dbzPend_q) begin
          lo_d      = '1;
          hi_d      = aRaw_q;
          dbzFlag_d = 1'b1;
        end else if (isDiv_q) begin
          lo_d = quoFix;
          hi_d = remFix;
        end else begin
          lo_d = prodFix[WIDTH-1:0];
          hi_d = prodFix[2*WIDTH-1:WIDTH];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      aRaw_q    <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      dbzPend_q <= 1'b0;
      dbzFlag_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      aRaw_q    <= aRaw_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      dbzPend_q <= dbzPend_d;
      dbzFlag_q <= dbzFlag_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbzFlag_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit. Each launched operation pushes its
// expected HI/LO/div_by_zero onto a scoreboard queue; the entry is popped
// and compared when done pulses. Latency, busy length, HI/LO stability
// during RUN, ignored writes/starts and asynchronous reset are checked too.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         sbQ[$];
  int           checkCount = 0;
  int           errorCount = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkValue(input string tag, input logic [W-1:0] observed,
                            input logic [W-1:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour built from plain 64-bit arithmetic.
  function automatic exp_t modelOp(input logic [1:0] mop, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb);
    exp_t   e;
    longint sa, sb, sq, sr;
    logic [2*W-1:0] p;
    sa    = longint'($signed(ma));
    sb    = longint'($signed(mb));
    e.dbz = 1'b0;
    case (mop)
      2'b00: begin
        p    = sa * sb;
        e.hi = p[2*W-1:W];
        e.lo = p[W-1:0];
      end
      2'b01: begin
        p    = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
        e.hi = p[2*W-1:W];
        e.lo = p[W-1:0];
      end
      default: begin
        if (mb == '0) begin
          e.lo  = '1;
          e.hi  = ma;
          e.dbz = 1'b1;
        end else if (mop == 2'b10) begin
          sq   = sa / sb;
          sr   = sa % sb;
          e.lo = sq[W-1:0];
          e.hi = sr[W-1:0];
        end else begin
          e.lo = ma / mb;
          e.hi = ma % mb;
        end
      end
    endcase
    return e;
  endfunction

  // Drive one start pulse (optionally with a same-cycle MTLO write that must
  // be dropped), push the expectation, and check state just after E0.
  task automatic applyStimulus(input logic [1:0] sop, input logic [W-1:0] sa,
                               input logic [W-1:0] sb, input logic withWrLo);
    op    = sop;
    a     = sa;
    b     = sb;
    start = 1'b1;
    wr_lo = withWrLo;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    wr_lo = 1'b0;
    sbQ.push_back(modelOp(sop, sa, sb));
    checkValue("busy_after_start", busy, 1'b1);
    checkValue("dbz_cleared_on_start", div_by_zero, 1'b0);
    checkValue("lo_held_at_start", lo, modelLo);
    checkValue("hi_held_at_start", hi, modelHi);
  endtask

  // Wait (bounded) for done, checking latency, busy length and HI/LO
  // stability. At edge injectAt a second start plus MTLO write is driven for
  // one cycle; both must be ignored while busy.
  task automatic waitDone(input int injectAt);
    int  edgeNum;
    int  busyCnt;
    bit  seen;
    edgeNum = 1;
    busyCnt = 1;
    seen    = 1'b0;
    while (!seen && edgeNum < 60) begin
      if (edgeNum == injectAt) begin
        start = 1'b1;
        op    = 2'b10;
        a     = 32'h0000_0005;
        b     = 32'h0000_0000;
        wr_lo = 1'b1;
        wdata = 32'hBAD0_BAD0;
      end
      if (edgeNum == injectAt + 1) begin
        start = 1'b0;
        wr_lo = 1'b0;
      end
      @(posedge clk); #1;
      edgeNum++;
      if (edgeNum == 12) begin
        checkValue("hi_stable_in_run", hi, modelHi);
        checkValue("lo_stable_in_run", lo, modelLo);
      end
      if (done) seen = 1'b1;
      else if (busy) busyCnt++;
    end
    start = 1'b0;
    wr_lo = 1'b0;
    checkValue("done_seen", seen, 1'b1);
    checkValue("done_latency", edgeNum, 34);
    checkValue("busy_cycles", busyCnt, 33);
    checkValue("busy_low_at_done", busy, 1'b0);
  endtask

  // Pop the oldest expectation and compare it with the committed result.
  task automatic checkOutput();
    exp_t e;
    checkCount++;
    assert (sbQ.size() > 0)
    else begin
      errorCount++;
      $error("[TB] FAIL scoreboard_empty: observed %0d expected >0", sbQ.size());
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkValue("hi_result", hi, e.hi);
      checkValue("lo_result", lo, e.lo);
      checkValue("dbz_result", div_by_zero, e.dbz);
      modelHi = e.hi;
      modelLo = e.lo;
    end
  endtask

  initial begin
    int doneCnt;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("rst_hi", hi, '0);
    checkValue("rst_lo", lo, '0);
    checkValue("rst_busy", busy, 1'b0);
    checkValue("rst_done", done, 1'b0);
    checkValue("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // MTHI then MTLO in IDLE.
    wr_hi = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    checkValue("mthi_hi", hi, 32'h1234_5678);
    checkValue("mthi_lo_untouched", lo, '0);
    modelHi = 32'h1234_5678;
    wr_lo = 1'b1;
    wdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    checkValue("mtlo_lo", lo, 32'hCAFE_BABE);
    modelLo = 32'hCAFE_BABE;

    // MULTU max*max with an ignored start+MTLO injected mid-RUN.
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitDone(6);
    checkOutput();
    checkValue("multu_hi_const", hi, 32'hFFFF_FFFE);
    checkValue("multu_lo_const", lo, 32'h0000_0001);

    // MULT -3*7, then DIV -7/2 launched in the done cycle.
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    waitDone(0);
    checkOutput();
    checkValue("mult_lo_const", lo, 32'hFFFF_FFEB);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    waitDone(0);
    checkOutput();
    checkValue("div_lo_const", lo, 32'hFFFF_FFFD);
    checkValue("div_hi_const", hi, 32'hFFFF_FFFF);

    // Divide by zero, then the next start clears the flag.
    applyStimulus(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
    waitDone(0);
    checkValue("dbz_with_done", div_by_zero, 1'b1);
    checkOutput();
    @(posedge clk); #1;
    checkValue("dbz_sticky", div_by_zero, 1'b1);
    applyStimulus(2'b01, 32'h0000_0002, 32'h0000_0003, 1'b0);
    waitDone(0);
    checkOutput();

    // Signed overflow wraps without a flag.
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    waitDone(0);
    checkOutput();
    checkValue("ovf_lo_const", lo, 32'h8000_0000);

    // Start and MTLO in the same cycle: the write is dropped (checked at E0).
    applyStimulus(2'b11, 32'h0000_03E8, 32'h0000_0007, 1'b1);
    waitDone(0);
    checkOutput();

    // Asynchronous reset mid-RUN discards the operation.
    @(negedge clk);
    applyStimulus(2'b01, 32'h0001_0001, 32'h0000_FFFF, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkValue("async_rst_busy", busy, 1'b0);
    checkValue("async_rst_hi", hi, '0);
    checkValue("async_rst_lo", lo, '0);
    void'(sbQ.pop_back());
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkValue("no_done_after_rst", doneCnt, 0);

    // Fresh operations after reset, including a few random ones.
    applyStimulus(2'b01, 32'h0000_1234, 32'h0000_5678, 1'b0);
    waitDone(0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), $urandom, $urandom_range(1, 32'h7FFF_FFFF), 1'b0);
      waitDone(0);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
